booth_mult: RTL and testbench
=============================

// Module: booth_mult
// PURPOSE
//  Sequential radix-2 Booth multiplier; companion to the restoring divider in the mult/div unit.
//  Takes two WIDTH-bit signed operands from the datapath A/B registers on a control-unit request.
//  Produces a 2*WIDTH-bit product split into hi/lo for the HI/LO registers, one Booth step per clock.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH bits
// PORTS
//  clock     in   1      single clock; all state changes on posedge
//  reset     in   1      synchronous, active-low reset
//  multCtrl  in   1      start request, level from control unit; sampled only in IDLE
//  valueA    in   WIDTH  multiplicand, captured at start
//  valueB    in   WIDTH  multiplier, captured at start
//  hi        out  WIDTH  product[2*WIDTH-1:WIDTH], registered
//  lo        out  WIDTH  product[WIDTH-1:0], registered
//  multEnd   out  1      one-cycle done pulse, registered
//  busy      out  1      high in RUN and DONE
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, count=0; hi, lo, multEnd, busy and internal regs = 0.
//    Reset mid-operation aborts it; no multEnd is produced.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//    - IDLE, multCtrl==1: load M=valueA, Q=valueB, q_1=0, acc=0, count=0; go to RUN.
//    - RUN, one step per edge: {Q[0],q_1}==01 -> acc+=M; ==10 -> acc-=M; 00/11 -> no op.
//      Then arithmetic shift right of {acc,Q,q_1} by one; count++.
//    - RUN, on the edge performing step STEPS: write hi/lo from {acc,Q}; go to DONE.
//    - DONE: multEnd=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  - STEPS: WIDTH steps, or WIDTH+1 with MULT_UNSIGNED_EN.
//  - acc is WIDTH+1 bits (M sign-extended) so the most-negative M cannot overflow.
//  - Latency: start edge E0; hi/lo valid and multEnd high in the cycle after edge E0+STEPS.
//  - hi/lo hold the last product until the next completion; they are not cleared at start.
//  - multCtrl and operand changes during RUN/DONE are ignored; operands are used only at load.
//  - If multCtrl is still high when the FSM returns to IDLE, a new operation starts.
//    The control unit drops multCtrl on seeing multEnd.
//  - The product is exact two's complement; no overflow flag (full 2*WIDTH result).
// CONFIGURATION
//  MULT_UNSIGNED_EN defined:
//  - Adds input port multU (1 bit), sampled with multCtrl.
//  - Operands are extended to WIDTH+1 bits: zero-extended if multU==1, sign-extended otherwise.
//  - acc widens to WIDTH+2 bits; every operation takes WIDTH+1 steps.
//  - hi/lo take the low 2*WIDTH bits of the product.
//  MULT_UNSIGNED_EN undefined:
//  - No multU port; signed only; WIDTH steps.
// STRUCTURE
//  - Shared package mult_div_pkg:
//    - mult_state_t enum {IDLE, RUN, DONE};
//    - MD_WIDTH=32;
//    - count width constant $clog2(WIDTH+2).
//  - Sub-module booth_step:
//    - Purely combinational.
//    - Inputs acc, Q, q_1, M; outputs next acc, Q, q_1 (add/sub, then arithmetic shift right).
//    - Instantiated once; booth_mult keeps FSM, counter and registers.
// TESTING
//  - Reset held low 2 cycles: hi=lo=0, multEnd=0, busy=0; multCtrl=1 during reset is ignored.
//  - 7 x 2, start at E0: multEnd high only in the cycle after E0+32; hi=0x00000000, lo=0x0000000E.
//  - 0xFFFFFFFF x 0xFFFFFFFF (signed -1 x -1): hi=0x00000000, lo=0x00000001.
//  - 0x80000000 x 0x80000000: hi=0x40000000, lo=0x00000000.
//  - 0x7FFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFF, lo=0x80000001.
//  - Reset at count 10, then 3 x 5 started: first product discarded, no multEnd; hi/lo=0 until
//    the new result hi=0x00000000, lo=0x0000000F.
//  - With MULT_UNSIGNED_EN, multU=1, 0xFFFFFFFF x 0xFFFFFFFF:
//    hi=0xFFFFFFFE, lo=0x00000001, multEnd after E0+33.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and sizing constants for the mult/div unit.
// Pure declarations: no logic and no latency.
// Backpressure: not applicable.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = $clog2(MD_WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // The step counter must reach WIDTH+1 when the unsigned extension is built in.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M, then arithmetic shift right.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module booth_step #(
    parameter int OPW = 32
) (
    input  logic [OPW:0]   i_acc,
    input  logic [OPW-1:0] i_q,
    input  logic           i_q_1,
    input  logic [OPW:0]   i_m,
    output logic [OPW:0]   o_acc,
    output logic [OPW-1:0] o_q,
    output logic           o_q_1
);

    logic [OPW:0] w_sum;

    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_q_1})
            2'b01:   w_sum = i_acc + i_m;
            2'b10:   w_sum = i_acc - i_m;
            default: w_sum = i_acc;
        endcase
    end

    assign o_acc = {w_sum[OPW], w_sum[OPW:1]};
    assign o_q   = {w_sum[0], i_q[OPW-1:1]};
    assign o_q_1 = i_q[0];

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier, one step per clock; MULT_UNSIGNED_EN adds the multU port.
// Latency: start edge E0, product and multEnd pulse visible after edge E0+STEPS (WIDTH or WIDTH+1).
// Backpressure: none; multCtrl is only sampled in IDLE, and busy stays high through RUN and DONE.
module booth_mult
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             multCtrl,
`ifdef MULT_UNSIGNED_EN
    input  logic             multU,
`endif
    input  logic [WIDTH-1:0] valueA,
    input  logic [WIDTH-1:0] valueB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             multEnd,
    output logic             busy
);

`ifdef MULT_UNSIGNED_EN
    localparam int OPW = WIDTH + 1;
`else
    localparam int OPW = WIDTH;
`endif
    localparam int STEPS = OPW;
    localparam int CNT_W = cnt_width(WIDTH);

    mult_state_t      r_state;
    mult_state_t      w_next_state;
    logic             w_load;
    logic             w_last;

    logic [OPW:0]     r_m;
    logic [OPW:0]     r_acc;
    logic [OPW-1:0]   r_q;
    logic             r_q_1;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_mult_end;

    logic [OPW-1:0]   w_ext_a;
    logic [OPW-1:0]   w_ext_b;
    logic [OPW:0]     w_acc_nxt;
    logic [OPW-1:0]   w_q_nxt;
    logic             w_q_1_nxt;
    logic [2*WIDTH-1:0] w_prod;

`ifdef MULT_UNSIGNED_EN
    assign w_ext_a = {(multU ? 1'b0 : valueA[WIDTH-1]), valueA};
    assign w_ext_b = {(multU ? 1'b0 : valueB[WIDTH-1]), valueB};
`else
    assign w_ext_a = valueA;
    assign w_ext_b = valueB;
`endif

    booth_step #(
        .OPW (OPW)
    ) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .i_m   (r_m),
        .o_acc (w_acc_nxt),
        .o_q   (w_q_nxt),
        .o_q_1 (w_q_1_nxt)
    );

    // The widened accumulator guard bit is dropped; only the low 2*WIDTH bits are architectural.
    assign w_prod = (2*WIDTH)'({w_acc_nxt, w_q_nxt});

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (multCtrl) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                if (r_count == CNT_W'(STEPS - 1)) begin
                    w_next_state = DONE;
                    w_last       = 1'b1;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_m        <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            r_q_1      <= 1'b0;
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_mult_end <= 1'b0;
        end else begin
            r_mult_end <= w_last;
            if (w_load) begin
                r_m     <= {w_ext_a[OPW-1], w_ext_a};
                r_acc   <= '0;
                r_q     <= w_ext_b;
                r_q_1   <= 1'b0;
                r_count <= '0;
            end else if (r_state == RUN) begin
                r_acc   <= w_acc_nxt;
                r_q     <= w_q_nxt;
                r_q_1   <= w_q_1_nxt;
                r_count <= r_count + 1'b1;
            end
            if (w_last) begin
                r_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign multEnd = r_mult_end;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed corner products, an aborted run, and random operands
// compared against plain-arithmetic multiplication.
module tb_booth_mult;

    localparam int W = 32;
`ifdef MULT_UNSIGNED_EN
    localparam int STEPS = W + 1;
`else
    localparam int STEPS = W;
`endif

    logic           clock    = 1'b0;
    logic           reset    = 1'b0;
    logic           multCtrl = 1'b0;
    logic [W-1:0]   valueA   = '0;
    logic [W-1:0]   valueB   = '0;
`ifdef MULT_UNSIGNED_EN
    logic           multU    = 1'b0;
`endif
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           multEnd;
    logic           busy;

    int             n_total = 0;
    int             n_pass  = 0;
    logic [2*W-1:0] prev_prod = '0;

    booth_mult #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .multCtrl (multCtrl),
`ifdef MULT_UNSIGNED_EN
        .multU    (multU),
`endif
        .valueA   (valueA),
        .valueB   (valueB),
        .hi       (hi),
        .lo       (lo),
        .multEnd  (multEnd),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic u);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        logic [2*W-1:0]        p;
        if (u) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end else begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            p  = sa * sb;
        end
        return p;
    endfunction

    // Control-unit style handshake: hold multCtrl until multEnd, scramble operands meanwhile.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic u,
                          input string tag);
        logic [2*W-1:0] exp;
        int k;
        exp = ref_prod(a, b, u);
        @(negedge clock);
        valueA   = a;
        valueB   = b;
        multCtrl = 1'b1;
`ifdef MULT_UNSIGNED_EN
        multU    = u;
`endif
        @(posedge clock);
        @(negedge clock);
        valueA = $urandom;
        valueB = $urandom;
`ifdef MULT_UNSIGNED_EN
        multU  = ~u;
`endif
        chk({tag, "_busy_run"}, 64'(busy), 64'd1);
        chk({tag, "_hold"}, {hi, lo}, prev_prod);
        k = 0;
        do begin
            @(posedge clock);
            k++;
            @(negedge clock);
        end while (!multEnd && k < STEPS + 8);
        chk({tag, "_latency"}, 64'(k), 64'(STEPS));
        chk({tag, "_prod"}, {hi, lo}, exp);
        chk({tag, "_busy_done"}, 64'(busy), 64'd1);
        multCtrl  = 1'b0;
        prev_prod = exp;
        @(negedge clock);
        chk({tag, "_end_pulse"}, {62'd0, multEnd, busy}, 64'd0);
    endtask

    initial begin
        bit seen_end;

        reset    = 1'b0;
        multCtrl = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_end", 64'(multEnd), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset    = 1'b1;
        multCtrl = 1'b0;
        @(negedge clock);
        chk("post_rst_idle", 64'(busy), 64'd0);

        run_op(32'd7, 32'd2, 1'b0, "7x2");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "m1xm1");
        run_op(32'h80000000, 32'h80000000, 1'b0, "minxmin");
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, "maxxm1");
        run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, "minxmax");

        // Abort a run after 10 steps; nothing from it may surface.
        @(negedge clock);
        valueA   = 32'h12345678;
        valueB   = 32'd9;
        multCtrl = 1'b1;
        @(posedge clock);
        @(negedge clock);
        multCtrl = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        seen_end = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (multEnd) seen_end = 1'b1;
        end
        chk("abort_no_end", 64'(seen_end), 64'd0);
        prev_prod = '0;
        run_op(32'd3, 32'd5, 1'b0, "3x5");

`ifdef MULT_UNSIGNED_EN
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "u_m1xm1");
        run_op(32'h80000000, 32'd2, 1'b1, "u_minx2");
`endif

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         u;
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) a = {a[W-1], {(W-1){~a[W-1]}}};
`ifdef MULT_UNSIGNED_EN
            u = 1'($urandom_range(0, 1));
`else
            u = 1'b0;
`endif
            run_op(a, b, u, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
